// File: rtl/hub_message_router_if.sv
// Handshake bundle between the hub message router and its neighbours.
//   dn_in_*  : downstream children -> hub (N channels, word i at [i*W +: W])
//   up_out_* : hub -> upstream parent
//   up_in_*  : upstream parent -> hub
//   dn_out_* : hub -> downstream children (same word on every channel)
// Modport slave is the router's view; master is the view of whatever drives it.
interface hub_message_router_if #(
    parameter int N = 2,
    parameter int W = 32
);
    logic [N*W-1:0] dn_in_data;
    logic [N-1:0]   dn_in_valid;
    logic [N-1:0]   dn_in_ready;

    logic [W-1:0]   up_out_data;
    logic           up_out_valid;
    logic           up_out_ready;

    logic [W-1:0]   up_in_data;
    logic           up_in_valid;
    logic           up_in_ready;

    logic [N*W-1:0] dn_out_data;
    logic [N-1:0]   dn_out_valid;
    logic [N-1:0]   dn_out_ready;

    modport slave (
        input  dn_in_data, dn_in_valid, output dn_in_ready,
        output up_out_data, up_out_valid, input up_out_ready,
        input  up_in_data, up_in_valid, output up_in_ready,
        output dn_out_data, dn_out_valid, input dn_out_ready
    );

    modport master (
        output dn_in_data, dn_in_valid, input dn_in_ready,
        input  up_out_data, up_out_valid, output up_out_ready,
        output up_in_data, up_in_valid, input up_in_ready,
        input  dn_out_data, dn_out_valid, output dn_out_ready
    );
endinterface

// File: rtl/hub_message_router.sv
// Message scheduler for one hub of the decoder tree.
//   Upstream path  : round-robin merge of N downstream channels into a 1-entry
//                    output register (1-cycle latency, 1 msg/cycle sustained).
//   Downstream path: 1 holding register plus a pending mask; broadcast (dest all
//                    ones) or unicast, each child port handshakes independently.
//   Status         : registered OR-reductions of the children's flags.
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   bus             hub_message_router_if.slave handshake bundle
//   downstream_has_message_flying / downstream_has_odd_clusters  per-child status in
//   upstream_has_message_flying  / upstream_has_odd_clusters    registered status out
//   bad_dest        1-cycle pulse when a unicast destination >= N is dropped
module hub_message_router #(
    parameter int DOWNSTREAM_FIFO_COUNT = 2,
    parameter int HUB_FIFO_WIDTH        = 32,
    parameter int DEST_WIDTH            = 8
) (
    input  logic                             clk,
    input  logic                             reset,
    hub_message_router_if.slave              bus,
    input  logic [DOWNSTREAM_FIFO_COUNT-1:0] downstream_has_message_flying,
    input  logic [DOWNSTREAM_FIFO_COUNT-1:0] downstream_has_odd_clusters,
    output logic                             upstream_has_message_flying,
    output logic                             upstream_has_odd_clusters,
    output logic                             bad_dest
);
    localparam int N  = DOWNSTREAM_FIFO_COUNT;
    localparam int W  = HUB_FIFO_WIDTH;
    localparam int D  = DEST_WIDTH;
    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0]  ptr_q, ptr_d;
    logic [W-1:0]   up_q, up_d;
    logic           up_vld_q, up_vld_d;
    logic [W-1:0]   hold_q, hold_d;
    logic [N-1:0]   pend_q, pend_d;
    logic           bad_q, bad_d;
    logic           fly_q, odd_q;

    logic           up_load;
    logic           lo_any, hi_any, gnt_found;
    logic [PW-1:0]  lo_idx, hi_idx, gnt_idx;
    logic           dn_accept;
    logic [D-1:0]   dest;

    // Round robin: the lowest valid port at or above ptr wins; if none, the
    // lowest valid port overall (the wrap-around case).
    always_comb begin
        lo_any = 1'b0;
        hi_any = 1'b0;
        lo_idx = '0;
        hi_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (bus.dn_in_valid[i]) begin
                lo_any = 1'b1;
                lo_idx = PW'(i);
                if (PW'(i) >= ptr_q) begin
                    hi_any = 1'b1;
                    hi_idx = PW'(i);
                end
            end
        end
        gnt_found = lo_any;
        gnt_idx   = hi_any ? hi_idx : lo_idx;
    end

    assign up_load = !up_vld_q || bus.up_out_ready;

    always_comb begin
        ptr_d    = ptr_q;
        up_d     = up_q;
        up_vld_d = up_vld_q;
        if (up_load) begin
            up_vld_d = gnt_found;
            if (gnt_found) begin
                up_d  = bus.dn_in_data[gnt_idx*W +: W];
                ptr_d = (gnt_idx == PW'(N - 1)) ? '0 : gnt_idx + 1'b1;
            end
        end
    end

    // Ready outputs are held low during reset so nothing is consumed then.
    assign bus.dn_in_ready = (!reset && up_load && gnt_found) ? (N'(1) << gnt_idx) : '0;
    assign bus.up_in_ready = !reset && ((pend_q & ~bus.dn_out_ready) == '0);

    assign dn_accept = bus.up_in_valid && bus.up_in_ready;
    assign dest      = bus.up_in_data[W-1 -: D];

    // A refill overwrites the mask in the same cycle the last pending port accepts.
    always_comb begin
        hold_d = hold_q;
        pend_d = pend_q & ~bus.dn_out_ready;
        bad_d  = 1'b0;
        if (dn_accept) begin
            if (&dest) begin
                hold_d = bus.up_in_data;
                pend_d = '1;
            end else if (int'(dest) < N) begin
                hold_d = bus.up_in_data;
                pend_d = N'(1) << dest;
            end else begin
                bad_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q    <= '0;
            up_q     <= '0;
            up_vld_q <= 1'b0;
            hold_q   <= '0;
            pend_q   <= '0;
            bad_q    <= 1'b0;
            fly_q    <= 1'b0;
            odd_q    <= 1'b0;
        end else begin
            ptr_q    <= ptr_d;
            up_q     <= up_d;
            up_vld_q <= up_vld_d;
            hold_q   <= hold_d;
            pend_q   <= pend_d;
            bad_q    <= bad_d;
            fly_q    <= (|downstream_has_message_flying) | up_vld_q | (|pend_q)
                        | (|bus.dn_in_valid) | bus.up_in_valid;
            odd_q    <= |downstream_has_odd_clusters;
        end
    end

    assign bus.up_out_data              = up_q;
    assign bus.up_out_valid             = up_vld_q;
    assign bus.dn_out_data              = {N{hold_q}};
    assign bus.dn_out_valid             = pend_q;
    assign upstream_has_message_flying  = fly_q;
    assign upstream_has_odd_clusters    = odd_q;
    assign bad_dest                     = bad_q;
endmodule

// File: tb/tb_hub_message_router.sv
// Cycle-by-cycle directed vectors for hub_message_router with N=2, W=32, D=8.
// Each row drives inputs after the falling edge, checks outputs before the next
// rising edge; expected values are worked out by hand from the row history.
module tb_hub_message_router;
    localparam int N = 2;
    localparam int W = 32;

    logic clk = 1'b0;
    logic reset;
    logic [N-1:0] dn_fly, dn_odd;
    logic up_fly, up_odd, bad;

    always #5 clk = ~clk;

    hub_message_router_if #(.N(N), .W(W)) bus ();

    hub_message_router #(
        .DOWNSTREAM_FIFO_COUNT(N),
        .HUB_FIFO_WIDTH(W),
        .DEST_WIDTH(8)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus),
        .downstream_has_message_flying(dn_fly),
        .downstream_has_odd_clusters(dn_odd),
        .upstream_has_message_flying(up_fly),
        .upstream_has_odd_clusters(up_odd),
        .bad_dest(bad)
    );

    typedef struct {
        logic        rst;
        logic [1:0]  dv;
        logic [31:0] d0, d1;
        logic        uor, uiv;
        logic [31:0] uid;
        logic [1:0]  dor, fly, odd;
        logic [1:0]  e_dir;
        logic        e_uov;
        logic [31:0] e_uod;
        logic        e_uir;
        logic [1:0]  e_dov;
        logic [31:0] e_dod;
        logic        e_fly, e_odd, e_bad;
    } vec_t;

    localparam int NV = 32;
    vec_t tbl [NV];
    int   applied = 0;
    int   miscompares = 0;

    task automatic chk(input string nm, input int row, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s row %0d: got %h expected %h", nm, row, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        reset            = v.rst;
        bus.dn_in_valid  = v.dv;
        bus.dn_in_data   = {v.d1, v.d0};
        bus.up_out_ready = v.uor;
        bus.up_in_valid  = v.uiv;
        bus.up_in_data   = v.uid;
        bus.dn_out_ready = v.dor;
        dn_fly           = v.fly;
        dn_odd           = v.odd;
    endtask

    initial begin
        //            rst dv     d0           d1           uor uiv uid           dor    fly    odd    | dir    uov uod          uir dov    dod          fly odd bad
        tbl[0]  = '{1'b1, 2'b11, 32'h000000A0, 32'h000000B0, 1'b1, 1'b1, 32'hFF0000EE, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 32'h0, 1'b0, 2'b00, 32'h0, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 2'b11, 32'h000000A1, 32'h000000B1, 1'b1, 1'b0, 32'h0, 2'b00, 2'b00, 2'b00, 2'b01, 1'b0, 32'h0, 1'b1, 2'b00, 32'h0, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 2'b11, 32'h000000A2, 32'h000000B2, 1'b1, 1'b0, 32'h0, 2'b00, 2'b00, 2'b00, 2'b10, 1'b1, 32'h000000A1, 1'b1, 2'b00, 32'h0, 1'b1, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 2'b11, 32'h000000A3, 32'h000000B3, 1'b1, 1'b0, 32'h0, 2'b00, 2'b00, 2'b00, 2'b01, 1'b1, 32'h000000B2, 1'b1, 2'b00, 32'h0, 1'b1, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 2'b11, 32'h000000A4, 32'h000000B4, 1'b1, 1'b0, 32'h0, 2'b00, 2'b00, 2'b00, 2'b10, 1'b1, 32'h000000A3, 1'b1, 2'b00, 32'h0, 1'b1, 1'b0, 1'b0};
        // port 1 alone with ptr back at 0
        tbl[5]  = '{1'b0, 2'b10, 32'h000000A5, 32'h000000B5, 1'b1, 1'b0, 32'h0, 2'b00, 2'b00, 2'b00, 2'b10, 1'b1, 32'h000000B4, 1'b1, 2'b00, 32'h0, 1'b1, 1'b0, 1'b0};
        // five stalled cycles, input data keeps changing
        tbl[6]  = '{1'b0, 2'b11, 32'h000000A6, 32'h000000B6, 1'b0, 1'b0, 32'h0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 32'h000000B5, 1'b1, 2'b00, 32'h0, 1'b1, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 2'b11, 32'h000000A7, 32'h000000B7, 1'b0, 1'b0, 32'h0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 32'h000000B5, 1'b1, 2'b00, 32'h0, 1'b1, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 2'b11, 32'h000000A8, 32'h000000B8, 1'b0, 1'b0, 32'h0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 32'h000000B5, 1'b1, 2'b00, 32'h0, 1'b1, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 2'b11, 32'h000000A9, 32'h000000B9, 1'b0, 1'b0, 32'h0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 32'h000000B5, 1'b1, 2'b00, 32'h0, 1'b1, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 2'b11, 32'h00000A10, 32'h00000B10, 1'b0, 1'b0, 32'h0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 32'h000000B5, 1'b1, 2'b00, 32'h0, 1'b1, 1'b0, 1'b0};
        // drain with no valid input
        tbl[11] = '{1'b0, 2'b00, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 32'h000000B5, 1'b1, 2'b00, 32'h0, 1'b1, 1'b0, 1'b0};
        tbl[12] = '{1'b0, 2'b00, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 32'h0, 1'b1, 2'b00, 32'h0, 1'b1, 1'b0, 1'b0};
        // broadcast, port 0 then port 1, refill on the last accept
        tbl[13] = '{1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b1, 32'hFF0000C1, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 32'h0, 1'b1, 2'b00, 32'h0, 1'b0, 1'b0, 1'b0};
        tbl[14] = '{1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b1, 32'h010000C2, 2'b01, 2'b00, 2'b00, 2'b00, 1'b0, 32'h0, 1'b0, 2'b11, 32'hFF0000C1, 1'b1, 1'b0, 1'b0};
        tbl[15] = '{1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b1, 32'h010000C2, 2'b10, 2'b00, 2'b00, 2'b00, 1'b0, 32'h0, 1'b1, 2'b10, 32'hFF0000C1, 1'b1, 1'b0, 1'b0};
        // unicast to port 1, then an out-of-range destination
        tbl[16] = '{1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 32'h0, 1'b0, 2'b10, 32'h010000C2, 1'b1, 1'b0, 1'b0};
        tbl[17] = '{1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b1, 32'h050000C3, 2'b10, 2'b00, 2'b00, 2'b00, 1'b0, 32'h0, 1'b1, 2'b10, 32'h010000C2, 1'b1, 1'b0, 1'b0};
        tbl[18] = '{1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 32'h0, 1'b1, 2'b00, 32'h0, 1'b1, 1'b0, 1'b1};
        tbl[19] = '{1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 32'h0, 1'b1, 2'b00, 32'h0, 1'b0, 1'b0, 1'b0};
        // broadcast accepted by both ports in one cycle
        tbl[20] = '{1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b1, 32'hFF0000C4, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 32'h0, 1'b1, 2'b00, 32'h0, 1'b0, 1'b0, 1'b0};
        tbl[21] = '{1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 2'b11, 2'b00, 2'b00, 2'b00, 1'b0, 32'h0, 1'b1, 2'b11, 32'hFF0000C4, 1'b1, 1'b0, 1'b0};
        tbl[22] = '{1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 32'h0, 1'b1, 2'b00, 32'h0, 1'b1, 1'b0, 1'b0};
        // status reductions
        tbl[23] = '{1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 2'b00, 2'b00, 2'b10, 2'b00, 1'b0, 32'h0, 1'b1, 2'b00, 32'h0, 1'b0, 1'b0, 1'b0};
        tbl[24] = '{1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 32'h0, 1'b1, 2'b00, 32'h0, 1'b0, 1'b1, 1'b0};
        tbl[25] = '{1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 2'b00, 2'b01, 2'b00, 2'b00, 1'b0, 32'h0, 1'b1, 2'b00, 32'h0, 1'b0, 1'b0, 1'b0};
        tbl[26] = '{1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 32'h0, 1'b1, 2'b00, 32'h0, 1'b1, 1'b0, 1'b0};
        // simultaneous upstream grant and downstream accept, then reset mid-transfer
        tbl[27] = '{1'b0, 2'b01, 32'h00000A27, 32'h0, 1'b0, 1'b1, 32'hFF0000C5, 2'b00, 2'b00, 2'b00, 2'b01, 1'b0, 32'h0, 1'b1, 2'b00, 32'h0, 1'b0, 1'b0, 1'b0};
        tbl[28] = '{1'b1, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 32'h00000A27, 1'b0, 2'b11, 32'hFF0000C5, 1'b1, 1'b0, 1'b0};
        tbl[29] = '{1'b1, 2'b00, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0, 2'b11, 2'b00, 2'b00, 2'b00, 1'b0, 32'h0, 1'b0, 2'b00, 32'h0, 1'b0, 1'b0, 1'b0};
        tbl[30] = '{1'b0, 2'b00, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0, 2'b11, 2'b00, 2'b00, 2'b00, 1'b0, 32'h0, 1'b1, 2'b00, 32'h0, 1'b0, 1'b0, 1'b0};
        // pointer restarted at 0 by the reset
        tbl[31] = '{1'b0, 2'b11, 32'h00000A31, 32'h00000B31, 1'b1, 1'b0, 32'h0, 2'b00, 2'b00, 2'b00, 2'b01, 1'b0, 32'h0, 1'b1, 2'b00, 32'h0, 1'b0, 1'b0, 1'b0};

        drive(tbl[0]);
        repeat (2) @(negedge clk);

        for (int r = 0; r < NV; r++) begin
            drive(tbl[r]);
            #2;
            applied++;
            chk("dn_in_ready", r, 32'(bus.dn_in_ready), 32'(tbl[r].e_dir));
            chk("up_out_valid", r, 32'(bus.up_out_valid), 32'(tbl[r].e_uov));
            if (tbl[r].e_uov)
                chk("up_out_data", r, bus.up_out_data, tbl[r].e_uod);
            chk("up_in_ready", r, 32'(bus.up_in_ready), 32'(tbl[r].e_uir));
            chk("dn_out_valid", r, 32'(bus.dn_out_valid), 32'(tbl[r].e_dov));
            if (tbl[r].e_dov != 2'b00) begin
                chk("dn_out_data0", r, bus.dn_out_data[31:0], tbl[r].e_dod);
                chk("dn_out_data1", r, bus.dn_out_data[63:32], tbl[r].e_dod);
            end
            chk("up_fly", r, 32'(up_fly), 32'(tbl[r].e_fly));
            chk("up_odd", r, 32'(up_odd), 32'(tbl[r].e_odd));
            chk("bad_dest", r, 32'(bad), 32'(tbl[r].e_bad));
            @(negedge clk);
        end

        // Sustained back-to-back merge: after row 31 granted port 0, ptr is 1
        // and the register holds 0A31; grants must alternate every cycle.
        begin
            logic        p;
            logic [31:0] last;
            logic [31:0] w0, w1;
            p    = 1'b1;
            last = 32'h00000A31;
            for (int j = 0; j < 8; j++) begin
                w0 = 32'hC0000000 | 32'(j);
                w1 = 32'hD0000000 | 32'(j);
                bus.dn_in_valid  = 2'b11;
                bus.dn_in_data   = {w1, w0};
                bus.up_out_ready = 1'b1;
                #2;
                applied++;
                chk("b2b_ready", 100 + j, 32'(bus.dn_in_ready), p ? 32'd2 : 32'd1);
                chk("b2b_valid", 100 + j, 32'(bus.up_out_valid), 32'd1);
                chk("b2b_data", 100 + j, bus.up_out_data, last);
                last = p ? w1 : w0;
                p    = ~p;
                @(negedge clk);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end
endmodule
